// File: rtl/axi_pulsegen_core.sv
// ---------------------------------------------------------------------------
// axi_pulsegen_core
//
// Pulse-train engine that sits behind the axi_pulsegen register file. It takes
// the decoded CTRL / PERIOD / WIDTH / COUNT contents and turns them into a
// programmable pulse train, reporting progress back through STATUS.
//
// Ports
//   ACLK           system clock, rising edge
//   ARESETN        asynchronous active-low reset
//   enable_i       CTRL[0] level; dropping it aborts a running train
//   polarity_i     CTRL[1]; 0 = active-high pulse, 1 = active-low pulse
//   start_i        one-cycle start strobe (CTRL[2] write)
//   stop_i         one-cycle stop strobe (CTRL[3] write)
//   period_i       pulse period in cycles
//   width_i        active cycles per pulse
//   count_i        number of pulses, 0 = run continuously
//   pulse_o        registered pulse output
//   busy_o         high while a train is running
//   done_o         one-cycle strobe when a finite train completes
//   err_o          sticky flag set by a start with an invalid configuration
//   pulses_done_o  full periods emitted since the last accepted start
// ---------------------------------------------------------------------------
module axi_pulsegen_core #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 enable_i,
    input  logic                 polarity_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [CNT_WIDTH-1:0] period_i,
    input  logic [CNT_WIDTH-1:0] width_i,
    input  logic [CNT_WIDTH-1:0] count_i,
    output logic                 pulse_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] pulses_done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO = CNT_WIDTH'(2);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_WIDTH-1:0]   phase_cnt;
    logic [CNT_WIDTH-1:0]   phase_nxt;
    logic [CNT_WIDTH-1:0]   period_q;
    logic [CNT_WIDTH-1:0]   width_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic [CNT_WIDTH-1:0]   pulses_q;
    logic [CNT_WIDTH-1:0]   pulses_nxt;
    logic                   polarity_q;
    logic                   polarity_nxt;
    logic                   err_q;
    logic                   err_nxt;
    logic                   done_q;
    logic                   done_nxt;
    logic                   pulse_q;
    logic                   pulse_nxt;
    logic                   latch_cfg;
    logic                   start_ok;
    logic                   cfg_valid;
    logic                   abort;

    // A start only counts when the engine is enabled and no stop arrives in
    // the same cycle; stop or a dropped enable aborts any running train.
    assign start_ok  = start_i & enable_i & ~stop_i;
    assign cfg_valid = (width_i >= ONE) && (period_i >= TWO) && (width_i < period_i);
    assign abort     = stop_i | ~enable_i;

    // Next-state logic. The phase counter is loaded with (length - 1) on
    // entry to HIGH or LOW and counts down to zero, so each phase lasts
    // exactly its programmed number of cycles. Abort wins over completion,
    // but the final LOW cycle still counts its pulse when aborted.
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase_cnt;
        pulses_nxt = pulses_q;
        err_nxt    = err_q;
        done_nxt   = 1'b0;
        latch_cfg  = 1'b0;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    if (cfg_valid) begin
                        latch_cfg  = 1'b1;
                        pulses_nxt = '0;
                        err_nxt    = 1'b0;
                        phase_nxt  = width_i - ONE;
                        state_nxt  = HIGH;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            HIGH: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (phase_cnt == '0) begin
                    phase_nxt = period_q - width_q - ONE;
                    state_nxt = LOW;
                end else begin
                    phase_nxt = phase_cnt - ONE;
                end
            end

            LOW: begin
                if (phase_cnt == '0) begin
                    pulses_nxt = pulses_q + ONE;
                    if (abort) begin
                        state_nxt = IDLE;
                    end else if ((count_q != '0) && (pulses_nxt == count_q)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        phase_nxt = width_q - ONE;
                        state_nxt = HIGH;
                    end
                end else if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    phase_nxt = phase_cnt - ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The pulse output is registered from the next state so that the active
    // level appears on the same edge that accepts the start.
    always_comb begin
        polarity_nxt = latch_cfg ? polarity_i : polarity_q;
        pulse_nxt    = (state_nxt == HIGH) ? ~polarity_nxt : polarity_nxt;
    end

    // State, counters and the shadow copy of the configuration. The shadow
    // registers only load on an accepted start, so register writes during a
    // run do not disturb it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            period_q   <= '0;
            width_q    <= '0;
            count_q    <= '0;
            polarity_q <= 1'b0;
            pulses_q   <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase_cnt  <= phase_nxt;
            pulses_q   <= pulses_nxt;
            err_q      <= err_nxt;
            done_q     <= done_nxt;
            pulse_q    <= pulse_nxt;
            polarity_q <= polarity_nxt;
            if (latch_cfg) begin
                period_q <= period_i;
                width_q  <= width_i;
                count_q  <= count_i;
            end
        end
    end

    assign pulse_o       = pulse_q;
    assign busy_o        = (state != IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign pulses_done_o = pulses_q;

endmodule

// File: tb/tb_axi_pulsegen_core.sv
// ---------------------------------------------------------------------------
// tb_axi_pulsegen_core
//
// Self-checking bench for axi_pulsegen_core. A reference model tracks how
// many cycles have elapsed since the last accepted start and derives the
// pulse level and completed-period count from that elapsed time with plain
// modulo arithmetic. Each scenario task drives stimulus and compares the
// DUT outputs to the model every cycle, plus a few scenario-level checks.
// ---------------------------------------------------------------------------
module tb_axi_pulsegen_core;

    logic        ACLK;
    logic        ARESETN;
    logic        enable_i;
    logic        polarity_i;
    logic        start_i;
    logic        stop_i;
    logic [31:0] period_i;
    logic [31:0] width_i;
    logic [31:0] count_i;
    logic        pulse_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] pulses_done_o;

    int checks = 0;
    int errors = 0;

    axi_pulsegen_core #(.CNT_WIDTH(32)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .enable_i      (enable_i),
        .polarity_i    (polarity_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .period_i      (period_i),
        .width_i       (width_i),
        .count_i       (count_i),
        .pulse_o       (pulse_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .pulses_done_o (pulses_done_o)
    );

    // Free-running clock, 10 time units per cycle.
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Reference model: a running train is described only by its elapsed
    // cycle count m_t since the accepted start and its latched parameters.
    bit              m_run;
    longint unsigned m_t;
    logic [31:0]     m_per;
    logic [31:0]     m_wid;
    logic [31:0]     m_cnt;
    logic            m_pol;
    logic [31:0]     m_pulses;
    logic            m_err;
    logic            m_done;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_run    <= 1'b0;
            m_t      <= 0;
            m_per    <= '0;
            m_wid    <= '0;
            m_cnt    <= '0;
            m_pol    <= 1'b0;
            m_pulses <= '0;
            m_err    <= 1'b0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_run) begin
                if (((m_t + 1) % m_per) == 0) begin
                    m_pulses <= m_pulses + 32'd1;
                    if (enable_i && !stop_i && m_cnt != 0 && (m_pulses + 32'd1) == m_cnt) begin
                        m_run  <= 1'b0;
                        m_done <= 1'b1;
                    end
                end
                if (stop_i || !enable_i)
                    m_run <= 1'b0;
                m_t <= m_t + 1;
            end else if (start_i && enable_i && !stop_i) begin
                if (width_i >= 1 && period_i >= 2 && width_i < period_i) begin
                    m_per    <= period_i;
                    m_wid    <= width_i;
                    m_cnt    <= count_i;
                    m_pol    <= polarity_i;
                    m_pulses <= '0;
                    m_err    <= 1'b0;
                    m_run    <= 1'b1;
                    m_t      <= 0;
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    logic        exp_active;
    logic [35:0] exp_vec;
    logic [35:0] act_vec;

    always_comb begin
        exp_active = 1'b0;
        if (m_run && m_per != 0)
            exp_active = ((m_t % m_per) < m_wid);
        exp_vec = {exp_active ^ m_pol, m_run, m_done, m_err, m_pulses};
        act_vec = {pulse_o, busy_o, done_o, err_o, pulses_done_o};
    end

    task automatic test_reset();
        ARESETN    = 1'b0;
        enable_i   = 1'b1;
        polarity_i = 1'b1;
        start_i    = 1'b0;
        stop_i     = 1'b0;
        period_i   = 32'd10;
        width_i    = 32'd3;
        count_i    = 32'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            checks++;
            if (act_vec !== 36'h0) begin
                errors++;
                $display("[TB] FAIL reset_state cycle %0d: got %h expected %h", i, act_vec, 36'h0);
            end
        end
        ARESETN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge ACLK);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL reset_release cycle %0d: got %h expected %h", i, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_finite_train();
        int prev_rise = -1;
        int dones = 0;
        logic last_pulse = 1'b0;
        period_i = 32'd10; width_i = 32'd3; count_i = 32'd4; polarity_i = 1'b0; enable_i = 1'b1;
        for (int i = 0; i < 45; i++) begin
            start_i = (i == 0);
            @(negedge ACLK);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL finite cycle %0d: got %h expected %h", i, act_vec, exp_vec);
            end
            if (pulse_o && !last_pulse) begin
                if (prev_rise >= 0) begin
                    checks++;
                    if (i - prev_rise != 10) begin
                        errors++;
                        $display("[TB] FAIL finite_spacing: got %0d expected 10", i - prev_rise);
                    end
                end
                prev_rise = i;
            end
            last_pulse = pulse_o;
            if (done_o) dones++;
        end
        start_i = 1'b0;
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("[TB] FAIL finite_done_count: got %0d expected 1", dones);
        end
        checks++;
        if (pulses_done_o !== 32'd4 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL finite_final: got pulses=%0d busy=%b expected pulses=4 busy=0", pulses_done_o, busy_o);
        end
    endtask

    task automatic test_invalid_config();
        logic [31:0] bad_per [3] = '{32'd10, 32'd5, 32'd1};
        logic [31:0] bad_wid [3] = '{32'd0,  32'd5, 32'd0};
        polarity_i = 1'b0; count_i = 32'd2; enable_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            period_i = bad_per[k];
            width_i  = bad_wid[k];
            for (int i = 0; i < 3; i++) begin
                start_i = (i == 0);
                @(negedge ACLK);
                checks++;
                if (act_vec !== exp_vec) begin
                    errors++;
                    $display("[TB] FAIL invalid%0d cycle %0d: got %h expected %h", k, i, act_vec, exp_vec);
                end
            end
            checks++;
            if (err_o !== 1'b1 || busy_o !== 1'b0 || pulse_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL invalid%0d_flags: got err=%b busy=%b pulse=%b expected 1 0 0", k, err_o, busy_o, pulse_o);
            end
        end
        period_i = 32'd4; width_i = 32'd1;
        for (int i = 0; i < 10; i++) begin
            start_i = (i == 0);
            @(negedge ACLK);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL invalid_recover cycle %0d: got %h expected %h", i, act_vec, exp_vec);
            end
            if (i == 0) begin
                checks++;
                if (err_o !== 1'b0 || busy_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL invalid_clear: got err=%b busy=%b expected 0 1", err_o, busy_o);
                end
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_continuous_stop();
        int dones = 0;
        period_i = 32'd6; width_i = 32'd2; count_i = 32'd0; polarity_i = 1'b0; enable_i = 1'b1;
        for (int i = 0; i < 36; i++) begin
            start_i = (i == 0);
            stop_i  = (i == 31);
            @(negedge ACLK);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL continuous cycle %0d: got %h expected %h", i, act_vec, exp_vec);
            end
            if (done_o) dones++;
            if (i == 31) begin
                checks++;
                if (pulse_o !== 1'b0 || busy_o !== 1'b0 || pulses_done_o !== 32'd5) begin
                    errors++;
                    $display("[TB] FAIL continuous_stop: got pulse=%b busy=%b pulses=%0d expected 0 0 5", pulse_o, busy_o, pulses_done_o);
                end
            end
        end
        stop_i = 1'b0;
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL continuous_done: got %0d expected 0", dones);
        end
    endtask

    task automatic test_polarity();
        int dones = 0;
        int low_cycles = 0;
        period_i = 32'd4; width_i = 32'd1; count_i = 32'd2; polarity_i = 1'b1; enable_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            start_i = (i == 0);
            @(negedge ACLK);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL polarity cycle %0d: got %h expected %h", i, act_vec, exp_vec);
            end
            if (done_o) dones++;
            if (busy_o && !pulse_o) low_cycles++;
        end
        start_i = 1'b0;
        checks++;
        if (dones !== 1 || low_cycles !== 2 || pulses_done_o !== 32'd2 || pulse_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL polarity_summary: got done=%0d low=%0d pulses=%0d idle=%b expected 1 2 2 1",
                     dones, low_cycles, pulses_done_o, pulse_o);
        end
    endtask

    task automatic test_abort_final();
        int dones = 0;
        period_i = 32'd4; width_i = 32'd1; count_i = 32'd2; polarity_i = 1'b0; enable_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            start_i = (i == 0);
            stop_i  = (i == 8);
            @(negedge ACLK);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL abort_final cycle %0d: got %h expected %h", i, act_vec, exp_vec);
            end
            if (done_o) dones++;
        end
        stop_i = 1'b0;
        checks++;
        if (dones !== 0 || pulses_done_o !== 32'd2 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_final_summary: got done=%0d pulses=%0d busy=%b expected 0 2 0", dones, pulses_done_o, busy_o);
        end
    endtask

    task automatic test_busy_start();
        int prev_rise = -1;
        logic last_pulse = 1'b0;
        period_i = 32'd10; width_i = 32'd3; count_i = 32'd4; polarity_i = 1'b0; enable_i = 1'b1;
        for (int i = 0; i < 45; i++) begin
            start_i = (i == 0) || (i == 15) || (i == 27);
            if (i == 15) period_i = 32'd100;
            @(negedge ACLK);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL busy_start cycle %0d: got %h expected %h", i, act_vec, exp_vec);
            end
            if (pulse_o && !last_pulse) begin
                if (prev_rise >= 0) begin
                    checks++;
                    if (i - prev_rise != 10) begin
                        errors++;
                        $display("[TB] FAIL busy_start_spacing: got %0d expected 10", i - prev_rise);
                    end
                end
                prev_rise = i;
            end
            last_pulse = pulse_o;
        end
        start_i  = 1'b0;
        period_i = 32'd10;
        checks++;
        if (pulses_done_o !== 32'd4) begin
            errors++;
            $display("[TB] FAIL busy_start_pulses: got %0d expected 4", pulses_done_o);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        period_i = 32'd10; width_i = 32'd3; count_i = 32'd4; polarity_i = 1'b0; enable_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            start_i = (i == 0);
            @(negedge ACLK);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL midrun cycle %0d: got %h expected %h", i, act_vec, exp_vec);
            end
        end
        start_i = 1'b0;
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if (act_vec !== 36'h0) begin
            errors++;
            $display("[TB] FAIL midrun_reset: got %h expected %h", act_vec, 36'h0);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL midrun_after cycle %0d: got %h expected %h", i, act_vec, exp_vec);
            end
            if (done_o) dones++;
        end
        checks++;
        if (dones !== 0 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_done: got done=%0d busy=%b expected 0 0", dones, busy_o);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            period_i   = $urandom_range(14, 0);
            width_i    = $urandom_range(12, 0);
            count_i    = $urandom_range(4, 0);
            polarity_i = 1'($urandom_range(1, 0));
            for (int c = 0; c < 60; c++) begin
                start_i  = (c == 0) || ($urandom_range(15, 0) == 0);
                stop_i   = (c > 2) && ($urandom_range(40, 0) == 0);
                enable_i = !((c > 2) && ($urandom_range(50, 0) == 0));
                if ($urandom_range(20, 0) == 0) period_i = $urandom_range(14, 0);
                @(negedge ACLK);
                checks++;
                if (act_vec !== exp_vec) begin
                    errors++;
                    $display("[TB] FAIL random run %0d cycle %0d: got %h expected %h", r, c, act_vec, exp_vec);
                end
            end
            start_i  = 1'b0;
            stop_i   = 1'b1;
            enable_i = 1'b1;
            @(negedge ACLK);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL random run %0d drain: got %h expected %h", r, act_vec, exp_vec);
            end
            stop_i = 1'b0;
        end
    endtask

    // Hard time limit in case the clock or a scenario wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_finite_train();
        test_invalid_config();
        test_continuous_stop();
        test_polarity();
        test_abort_final();
        test_busy_start();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_pulsegen_core.md
Name: axi_pulsegen_core

Overview:
Pulse-generation engine behind the AXI4-Lite register file of the axi_pulsegen IP. It consumes decoded register contents and control strobes (CTRL, PERIOD, WIDTH, COUNT) from the slave register block. It produces a programmable pulse train plus status (busy, done, error, pulses emitted), which the register file reads back through STATUS. Everything runs in the AXI clock domain.

Parameters:
- CNT_WIDTH, 32, width of the period, width, count and pulse-count fields; must equal the AXI data width (32).

Ports:
- ACLK  in  1  system clock; all logic is on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- enable_i  in  1  CTRL[0]; level; 0 forces abort to IDLE.
- polarity_i  in  1  CTRL[1]; 0 = active-high pulse, 1 = active-low pulse.
- start_i  in  1  one-cycle strobe from a write of CTRL[2]=1.
- stop_i  in  1  one-cycle strobe from a write of CTRL[3]=1.
- period_i  in  CNT_WIDTH  PERIOD register, in cycles.
- width_i  in  CNT_WIDTH  WIDTH register, active cycles per pulse.
- count_i  in  CNT_WIDTH  COUNT register; 0 = continuous.
- pulse_o  out  1  registered pulse output.
- busy_o  out  1  high while in HIGH or LOW state.
- done_o  out  1  one-cycle strobe when a finite train completes.
- err_o  out  1  sticky invalid-configuration flag.
- pulses_done_o  out  CNT_WIDTH  pulses emitted since the last accepted start.

Behaviour:
- Reset (async assert, sync-released by the system):
  - state = IDLE.
  - pulse_o = 0. It holds 0 even when polarity_i = 1, because the shadow polarity also resets to 0.
  - busy_o = 0, done_o = 0, err_o = 0, pulses_done_o = 0.
  - All shadow registers = 0.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - pulse_o = inactive level of the shadow polarity.
  - A start is accepted when start_i=1 & enable_i=1 & stop_i=0.
  - Config is valid iff width_i >= 1, period_i >= 2 and width_i < period_i.
  - Accepted start with valid config:
    - Latch period, width, count and polarity into the shadow registers.
    - Clear pulses_done_o and err_o.
    - Load the phase counter with width-1; next state = HIGH.
  - Accepted start with invalid config: set err_o=1, stay in IDLE, pulse_o unchanged.
- Latency: start sampled at edge N -> pulse_o active and busy_o=1 from edge N (visible in cycle N+1).
- HIGH:
  - pulse_o active for exactly width cycles.
  - When the phase counter = 0: load period-width-1 and go to LOW.
- LOW:
  - pulse_o inactive for exactly period-width cycles.
  - When the phase counter = 0, pulses_done_o increments, and then:
    - If count != 0 and the incremented value == count: go to IDLE and pulse done_o=1 for one cycle (the same edge busy_o drops).
    - Otherwise: load width-1 and go to HIGH.
- Timing consequences:
  - Rising edges of the active level are exactly period cycles apart.
  - pulses_done_o updates at the end of each full period.
- Continuous mode (count=0):
  - Runs until stop/disable.
  - pulses_done_o wraps modulo 2^CNT_WIDTH.
- Abort (stop_i=1, or enable_i=0, in HIGH or LOW):
  - Next state = IDLE; pulse_o inactive and busy_o=0 from the next edge.
  - done_o is not asserted; pulses_done_o holds its value (a partial pulse is not counted).
- Priority on the same cycle: abort > natural completion > everything else.
  - If abort coincides with the final LOW cycle, the pulse is still counted (the increment happens), but done_o=0.
- start_i while busy: ignored; shadow registers are unchanged.
- start_i and stop_i in the same cycle while in IDLE: start is not accepted.
- Input register writes during a run have no effect until the next accepted start.
- Counters are unsigned, CNT_WIDTH bits; no arithmetic overflow is possible because width < period is guaranteed.
- Asynchronous reset mid-run: all outputs return to reset values immediately; no done_o.

Test Plan:
- Finite train: period=10, width=3, count=4, polarity=0, start.
  - pulse_o high 3 cycles, low 7 cycles, repeated 4 times.
  - Rising edges 10 cycles apart.
  - done_o one cycle after the 40th cycle; pulses_done_o=4; busy_o 0 afterwards.
- Invalid configs, each one started:
  - width=0 -> err_o=1, busy_o=0, pulse_o stays 0.
  - width=period=5 -> err_o=1.
  - period=1 -> err_o=1.
  - Then a valid start (period=4, width=1) -> err_o clears and the train runs.
- Continuous with stop: count=0, period=6, width=2.
  - After 5 periods, stop_i mid-HIGH -> pulse_o 0 the next cycle, busy_o 0, done_o never asserted, pulses_done_o=5.
- Inverted polarity: polarity=1, period=4, width=1, count=2.
  - pulse_o low 1 cycle, high 3 cycles, twice; done_o once; pulses_done_o=2.
- Busy start and live register writes: during the finite train above, pulse start_i and write period=100.
  - Timing unchanged (10-cycle period); pulses_done_o not cleared.
- Reset mid-run: deassert ARESETN during HIGH of pulse 2.
  - pulse_o=0, busy_o=0, pulses_done_o=0 immediately; no done_o after release.
